// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: IDLE/FETCH/EXEC sequencer with PC update and retire counter
// Fetches one word per instruction, holds it in EXEC until released, then redirects the PC.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [1:0]  branch,
  input  logic        zero,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic        capture, retire, taken;
  logic [31:0] pc4, br_off, pc_nxt;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign taken  = ((branch == 2'b01) && zero) || ((branch == 2'b10) && !zero);

  // Jump outranks any branch encoding present on the same instruction.
  always_comb begin
    pc_nxt = pc4;
    if (jump)
      pc_nxt = {pc4[31:28], instr[25:0], 2'b00};
    else if (taken)
      pc_nxt = pc4 + br_off;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= 32'h0;
      retired <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture)
        instr <= imem_rdata;
      if (retire) begin
        pc      <= pc_nxt;
        retired <= retired + 32'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
// Instruction vectors drive the main instance; a second instance exercises PC wrap from the top of memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, jump, zero, imem_ack;
  logic [1:0]  branch;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, instr, retired;
  logic [5:0]  opcode, funct;

  logic        w_imem_req, w_instr_valid;
  logic [31:0] w_imem_addr, w_pc, w_instr, w_retired;
  logic [5:0]  w_opcode, w_funct;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = 32'h0;
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .branch(branch), .zero(zero),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .retired(retired)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .branch(branch), .zero(zero),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .pc(w_pc), .instr(w_instr), .instr_valid(w_instr_valid), .opcode(w_opcode), .funct(w_funct),
    .retired(w_retired)
  );

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    int          stalls;
    logic        jump;
    logic [1:0]  branch;
    logic        zero;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] cur_pc;
    cur_pc = 32'hx;
    if (addr_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      cur_pc = addr_q.pop_front();
      chk($sformatf("v%0d_fetch_addr", idx), imem_addr, cur_pc);
    end
    chk("fetch_req", {31'h0, imem_req}, 32'd1);
    chk("fetch_valid", {31'h0, instr_valid}, 32'd0);
    if (idx == 0) chk("wrap_first_addr", w_imem_addr, 32'hFFFF_FFFC);
    if (idx == 1) chk("wrap_second_addr", w_imem_addr, 32'h0000_0000);
    stall = (v.stalls > 0);
    repeat (v.delay) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_req", {31'h0, imem_req}, 32'd1);
      chk("wait_valid", {31'h0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clk);
    chk("exec_valid", {31'h0, instr_valid}, 32'd1);
    chk("exec_req", {31'h0, imem_req}, 32'd0);
    chk("exec_instr", instr, v.rdata);
    chk("exec_opcode", {26'h0, opcode}, {26'h0, v.rdata[31:26]});
    chk("exec_funct", {26'h0, funct}, {26'h0, v.rdata[5:0]});
    imem_rdata = ~v.rdata;
    imem_ack   = (v.stalls > 0);
    repeat (v.stalls) begin
      @(negedge clk);
      chk("stall_pc", pc, cur_pc);
      chk("stall_instr", instr, v.rdata);
      chk("stall_retired", retired, exp_ret);
      chk("stall_valid", {31'h0, instr_valid}, 32'd1);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    jump     = v.jump;
    branch   = v.branch;
    zero     = v.zero;
    addr_q.push_back(v.next_pc);
    @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    chk("retired", retired, exp_ret);
    jump   = 1'b0;
    branch = 2'b00;
    zero   = 1'b0;
  endtask

  initial begin
    logic [31:0] cur_pc;
    vecs[0]  = '{32'h2001_0005, 0, 0, 1'b0, 2'b00, 1'b0, 32'h0000_3004};
    vecs[1]  = '{32'h8C22_0004, 0, 0, 1'b0, 2'b00, 1'b0, 32'h0000_3008};
    vecs[2]  = '{32'h0043_1820, 0, 0, 1'b0, 2'b00, 1'b0, 32'h0000_300C};
    vecs[3]  = '{32'hAC23_0008, 0, 0, 1'b0, 2'b11, 1'b1, 32'h0000_3010};
    vecs[4]  = '{32'h1000_FFFC, 0, 0, 1'b0, 2'b01, 1'b1, 32'h0000_3004};
    vecs[5]  = '{32'h0800_0C04, 0, 0, 1'b1, 2'b00, 1'b0, 32'h0000_3010};
    vecs[6]  = '{32'h1000_FFFC, 0, 0, 1'b0, 2'b01, 1'b0, 32'h0000_3014};
    vecs[7]  = '{32'h0800_0C08, 0, 0, 1'b1, 2'b00, 1'b0, 32'h0000_3020};
    vecs[8]  = '{32'h1400_0003, 0, 0, 1'b0, 2'b10, 1'b0, 32'h0000_3030};
    vecs[9]  = '{32'h0800_0C08, 0, 0, 1'b1, 2'b00, 1'b0, 32'h0000_3020};
    vecs[10] = '{32'h1400_0003, 0, 0, 1'b0, 2'b11, 1'b0, 32'h0000_3024};
    vecs[11] = '{32'h0800_0C10, 0, 0, 1'b1, 2'b00, 1'b0, 32'h0000_3040};
    vecs[12] = '{32'h0800_0C10, 0, 0, 1'b1, 2'b01, 1'b1, 32'h0000_3040};
    vecs[13] = '{32'h1400_0010, 3, 4, 1'b0, 2'b10, 1'b1, 32'h0000_3044};

    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch = 2'b00; zero = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    @(negedge clk);
    addr_q.push_back(32'h0000_3000);

    for (int i = 0; i < 14; i++)
      run_vec(vecs[i], i);

    // Abandon an instruction in EXEC with an asynchronous reset, then hold a stale ack through IDLE.
    cur_pc = addr_q.pop_front();
    chk("final_fetch_addr", imem_addr, cur_pc);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("pre_rst_valid", {31'h0, instr_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0000_3000);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("async_rst_req", {31'h0, imem_req}, 32'd0);
    chk("async_rst_retired", retired, 32'h0);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_3000);
    chk("post_rst_instr", instr, 32'h0);
    chk("post_rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("post_rst_retired", retired, 32'h0);
    imem_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port stall, input, 1: hold the current instruction in EXEC.
REQ-005 SHALL have port jump, input, 1: current instruction is an absolute jump, from the control unit.
REQ-006 SHALL have port branch, input, 2: 2'b01 = beq, 2'b10 = bne, 2'b00/2'b11 = no branch.
REQ-007 SHALL have port zero, input, 1: ALU zero flag for the current instruction.
REQ-008 SHALL have port imem_ack, input, 1: instruction memory data valid this cycle.
REQ-009 SHALL have port imem_rdata, input, 32: instruction word, valid when imem_ack=1.
REQ-010 SHALL have port imem_req, output, 1: fetch request.
REQ-011 SHALL have port imem_addr, output, 32: fetch address, equal to pc.
REQ-012 SHALL have port pc, output, 32: address of the current instruction.
REQ-013 SHALL have port instr, output, 32: current instruction register.
REQ-014 SHALL have port instr_valid, output, 1: instr holds a decoded-ready instruction.
REQ-015 SHALL have port opcode, output, 6: instr[31:26]; port funct, output, 6: instr[5:0].
REQ-016 SHALL have port retired, output, 32: count of retired instructions.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EXEC; IDLE->FETCH unconditionally on the first edge after reset release.
REQ-018 In FETCH: imem_req=1, imem_addr=pc; ack=1 captures imem_rdata into instr and moves to EXEC; ack=0 stays in FETCH with address stable.
REQ-019 An ack in the first FETCH cycle SHALL be accepted, giving a minimum of 2 cycles per instruction.
REQ-020 In EXEC: instr_valid=1 and imem_req=0; stall=1 holds pc, instr, retired and state unchanged.
REQ-021 In EXEC with stall=0 the instruction retires: pc<=next_pc, retired<=retired+1, state<=FETCH.
REQ-022 The jump, branch, zero and instr[25:0]/instr[15:0] fields SHALL be sampled only on the retire edge.
REQ-023 next_pc SHALL be computed as follows, with pc4 = pc+4 (mod 2^32):
- jump=1: {pc4[31:28], instr[25:0], 2'b00}
- else (branch=01 & zero) | (branch=10 & ~zero): pc4 + (sign-extended instr[15:0] << 2), mod 2^32
- else: pc4
REQ-024 jump SHALL take priority over branch when both are asserted.
REQ-025 All address arithmetic SHALL wrap: pc 32'hFFFF_FFFC with no redirect gives 32'h0000_0000.
REQ-026 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 imem_ack SHALL be ignored in IDLE and EXEC.
REQ-028 stall SHALL be ignored in IDLE and FETCH.
REQ-029 opcode and funct SHALL be pure slices of the instr register.
REQ-030 Outside EXEC, instr_valid=0 and instr keeps its last captured value.

Reset
REQ-031 rst_n=0 SHALL immediately force the following, independent of clk: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0.
REQ-032 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the request or instruction with no retirement counted; a late imem_ack after release SHALL be ignored while in IDLE.

Verification
REQ-033 SHALL cover sequential fetch: reset, then zero-wait ack for words at 0x3000/0x3004/0x3008 -> imem_addr 0x3000, 0x3004, 0x3008 on 2-cycle spacing; retired=3.
REQ-034 SHALL cover a taken beq at pc 0x3010 with instr[15:0]=16'hFFFC, branch=01, zero=1 -> next imem_addr 0x3004; same with zero=0 -> 0x3014.
REQ-035 SHALL cover bne at pc 0x3020 with imm 16'h0003, branch=10, zero=0 -> 0x3030; branch=11 -> 0x3024.
REQ-036 SHALL cover jump at pc 0x3040 with instr[25:0]=26'h0000C10, jump=1, branch=01, zero=1 -> 0x0000_3040 (jump wins).
REQ-037 SHALL cover stall and wait: ack delayed 3 cycles -> imem_addr stable and instr_valid=0 throughout; stall held 4 cycles in EXEC -> pc, retired and instr unchanged, then exactly one retirement.
REQ-038 SHALL cover wrap and reset: RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0; rst_n pulsed low mid-EXEC -> outputs immediately take reset values with retired=0.
